// File: rtl/nvram_pkg.sv
// Shared types and defaults for the NVRAM upload responder.
package nvram_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    SERVE = 2'd2,
    DONE  = 2'd3
  } nv_state_e;

  localparam logic [7:0] NVRAM_INDEX_DEFAULT = 8'd4;
endpackage

// File: rtl/nvram_autosave_timer.sv
// Counts quiet vblanks after the last NVRAM write and arms an autosave request.
module nvram_autosave_timer #(
  parameter logic [7:0] FRAMES = 8'd120
) (
  input  logic clk,
  input  logic reset_n,
  input  logic hit,
  input  logic dirty,
  input  logic vblank,
  input  logic autosave_en,
  input  logic clear,
  output logic armed
);
  logic       r_vb_d;
  logic [7:0] r_cnt;
  logic       r_armed;
  logic       w_vb_rise;

  assign w_vb_rise = vblank && !r_vb_d;
  assign armed     = r_armed;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vb_d  <= 1'b0;
      r_cnt   <= 8'd0;
      r_armed <= 1'b0;
    end else begin
      r_vb_d <= vblank;
      // A fresh write restarts the quiet period; so does an ended or abandoned save.
      if (hit || clear) begin
        r_cnt   <= 8'd0;
        r_armed <= 1'b0;
      end else begin
        if (w_vb_rise && dirty && (r_cnt < FRAMES))
          r_cnt <= r_cnt + 8'd1;
        if ((r_cnt == FRAMES) && autosave_en)
          r_armed <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/nvram_upload.sv
// HPS ioctl upload responder: streams game NVRAM back to the HPS and holds the CPU meanwhile.
module nvram_upload
  import nvram_pkg::*;
#(
  parameter logic [7:0]  INDEX           = NVRAM_INDEX_DEFAULT,
  parameter int          AW              = 10,
  parameter logic [15:0] BASE            = 16'hC000,
  parameter logic [7:0]  AUTOSAVE_FRAMES = 8'd120,
  parameter int          REQ_TMO         = 20
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_upload_req,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_q,
  input  logic          cpu_wr,
  input  logic [15:0]   cpu_addr,
  input  logic          vblank,
  input  logic          save_trig,
  input  logic          autosave_en,
  output logic          cpu_pause,
  output logic          dirty
);
  localparam logic [REQ_TMO-1:0] TMO_LAST = {REQ_TMO{1'b1}} - 1'b1;

  nv_state_e        r_state;
  logic             r_req;
  logic             r_pause;
  logic             r_dirty;
  logic             r_act_d;
  logic [REQ_TMO-1:0] r_tmo;

  logic [AW-1:0]    r_ram_addr;
  logic             r_ram_rd;
  logic             r_cap;
  logic             r_oor1;
  logic             r_oor2;
  logic [7:0]       r_din;

  logic w_active;
  logic w_act_rise;
  logic w_hit;
  logic w_oor;
  logic w_rd_ok;
  logic w_timeout;
  logic w_clear;
  logic w_armed;

  assign w_active   = ioctl_upload && (ioctl_index == INDEX);
  assign w_act_rise = w_active && !r_act_d;
  assign w_hit      = cpu_wr && (cpu_addr[15:AW] == BASE[15:AW]);
  assign w_oor      = |ioctl_addr[24:AW];
  assign w_rd_ok    = ioctl_rd && (r_state == SERVE);
  assign w_timeout  = (r_state == REQ) && !w_active && (r_tmo == TMO_LAST);
  assign w_clear    = (r_state == DONE) || w_timeout;

  nvram_autosave_timer #(.FRAMES(AUTOSAVE_FRAMES)) u_timer (
    .clk         (clk_sys),
    .reset_n     (reset_n),
    .hit         (w_hit),
    .dirty       (r_dirty),
    .vblank      (vblank),
    .autosave_en (autosave_en),
    .clear       (w_clear),
    .armed       (w_armed)
  );

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_pause <= 1'b0;
      r_dirty <= 1'b0;
      r_act_d <= 1'b0;
      r_tmo   <= '0;
    end else begin
      r_act_d <= w_active;
      // A write landing in the DONE clock must survive the clear.
      if (w_hit)
        r_dirty <= 1'b1;
      else if (r_state == DONE)
        r_dirty <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_act_rise) begin
            r_state <= SERVE;
            r_pause <= 1'b1;
          end else if (save_trig || w_armed) begin
            r_state <= REQ;
            r_req   <= 1'b1;
            r_tmo   <= '0;
          end
        end
        REQ: begin
          if (w_active) begin
            r_state <= SERVE;
            r_req   <= 1'b0;
            r_pause <= 1'b1;
          end else if (w_timeout) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        SERVE: begin
          if (!w_active)
            r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
          r_pause <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
          r_pause <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage read pipeline; out-of-range reads run alongside so 8'hFF lands with the same latency.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_ram_addr <= '0;
      r_ram_rd   <= 1'b0;
      r_cap      <= 1'b0;
      r_oor1     <= 1'b0;
      r_oor2     <= 1'b0;
      r_din      <= 8'h00;
    end else begin
      r_ram_rd <= w_rd_ok && !w_oor;
      r_oor1   <= w_rd_ok && w_oor;
      if (w_rd_ok && !w_oor)
        r_ram_addr <= ioctl_addr[AW-1:0];
      r_cap  <= r_ram_rd;
      r_oor2 <= r_oor1;
      if (r_cap)
        r_din <= ram_q;
      else if (r_oor2)
        r_din <= 8'hFF;
    end
  end

  assign ioctl_din        = r_din;
  assign ioctl_upload_req = r_req;
  assign ram_addr         = r_ram_addr;
  assign ram_rd           = r_ram_rd;
  assign cpu_pause        = r_pause;
  assign dirty            = r_dirty;
endmodule

// File: tb/tb_nvram_upload.sv
// Directed bench for nvram_upload: reset, autosave, read path, end of upload, timeout, filtering.
module tb_nvram_upload;
  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_upload_req;
  logic [9:0]  ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_q;
  logic        cpu_wr;
  logic [15:0] cpu_addr;
  logic        vblank;
  logic        save_trig;
  logic        autosave_en;
  logic        cpu_pause;
  logic        dirty;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [1024];

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (ram_rd) ram_q <= mem[ram_addr];
  end

  nvram_upload #(.REQ_TMO(4)) dut (
    .clk_sys          (clk_sys),
    .reset_n          (reset_n),
    .ioctl_upload     (ioctl_upload),
    .ioctl_index      (ioctl_index),
    .ioctl_rd         (ioctl_rd),
    .ioctl_addr       (ioctl_addr),
    .ioctl_din        (ioctl_din),
    .ioctl_upload_req (ioctl_upload_req),
    .ram_addr         (ram_addr),
    .ram_rd           (ram_rd),
    .ram_q            (ram_q),
    .cpu_wr           (cpu_wr),
    .cpu_addr         (cpu_addr),
    .vblank           (vblank),
    .save_trig        (save_trig),
    .autosave_en      (autosave_en),
    .cpu_pause        (cpu_pause),
    .dirty            (dirty)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a);
    cpu_wr = 1'b1; cpu_addr = a;
    tick();
    cpu_wr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    mem[10'h3FF] = 8'h5A;
    mem[10'h001] = 8'h33;
    mem[10'h002] = 8'h44;
    ram_q = 8'h00;
    reset_n = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd0; ioctl_rd = 1'b0;
    ioctl_addr = '0; cpu_wr = 1'b0; cpu_addr = '0; vblank = 1'b0;
    save_trig = 1'b0; autosave_en = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_din",   32'(ioctl_din), 32'h00);
    chk("rst_req",   32'(ioctl_upload_req), 32'd0);
    chk("rst_raddr", 32'(ram_addr), 32'd0);
    chk("rst_rd",    32'(ram_rd), 32'd0);
    chk("rst_pause", 32'(cpu_pause), 32'd0);
    chk("rst_dirty", 32'(dirty), 32'd0);

    // out-of-region write, then in-region write
    cpu_write(16'hB000);
    chk("wr_b000_dirty", 32'(dirty), 32'd0);
    cpu_write(16'hC010);
    chk("wr_c010_dirty", 32'(dirty), 32'd1);

    // 120 quiet vblank edges arm the autosave request
    autosave_en = 1'b1;
    for (int i = 0; i < 120; i++) begin
      vblank = 1'b1; tick();
      vblank = 1'b0; tick();
    end
    chk("autosave_req_pre", 32'(ioctl_upload_req), 32'd0);
    tick();
    chk("autosave_req", 32'(ioctl_upload_req), 32'd1);
    autosave_en = 1'b0;

    // HPS answers: enter SERVE
    ioctl_upload = 1'b1; ioctl_index = 8'd4;
    tick();
    chk("serve_pause", 32'(cpu_pause), 32'd1);
    chk("serve_req",   32'(ioctl_upload_req), 32'd0);

    ioctl_rd = 1'b1; ioctl_addr = 25'h3FF;
    tick();
    ioctl_rd = 1'b0;
    chk("rd3ff_ram_rd",   32'(ram_rd), 32'd1);
    chk("rd3ff_ram_addr", 32'(ram_addr), 32'h3FF);
    tick();
    chk("rd3ff_din_early", 32'(ioctl_din), 32'h00);
    tick();
    chk("rd3ff_din", 32'(ioctl_din), 32'h5A);

    ioctl_rd = 1'b1; ioctl_addr = 25'h400;
    tick();
    ioctl_rd = 1'b0;
    chk("rd400_ram_rd", 32'(ram_rd), 32'd0);
    tick();
    chk("rd400_din_hold", 32'(ioctl_din), 32'h5A);
    tick();
    chk("rd400_din", 32'(ioctl_din), 32'hFF);

    // back-to-back reads
    ioctl_rd = 1'b1; ioctl_addr = 25'h001;
    tick();
    ioctl_addr = 25'h002;
    tick();
    ioctl_rd = 1'b0;
    chk("b2b_ram_addr", 32'(ram_addr), 32'h002);
    tick();
    chk("b2b_din0", 32'(ioctl_din), 32'h33);
    tick();
    chk("b2b_din1", 32'(ioctl_din), 32'h44);
    chk("serve_pause_hold", 32'(cpu_pause), 32'd1);

    // end of upload with a write in the DONE clock
    ioctl_upload = 1'b0;
    tick();
    chk("done_pause", 32'(cpu_pause), 32'd1);
    cpu_write(16'hC000);
    chk("release_pause", 32'(cpu_pause), 32'd0);
    chk("done_hit_dirty", 32'(dirty), 32'd1);

    // reads in IDLE are ignored
    ioctl_rd = 1'b1; ioctl_addr = 25'h3FF;
    tick();
    ioctl_rd = 1'b0;
    chk("idle_rd_ram_rd", 32'(ram_rd), 32'd0);
    tick(); tick();
    chk("idle_rd_din", 32'(ioctl_din), 32'h44);

    // HPS-initiated upload clears dirty at the end
    ioctl_upload = 1'b1; ioctl_index = 8'd4;
    tick();
    chk("hps_pause", 32'(cpu_pause), 32'd1);
    ioctl_upload = 1'b0;
    tick(); tick();
    chk("hps_release", 32'(cpu_pause), 32'd0);
    chk("hps_dirty_clr", 32'(dirty), 32'd0);

    // wrong index is not active
    ioctl_upload = 1'b1; ioctl_index = 8'd0;
    ioctl_rd = 1'b1; ioctl_addr = 25'h005;
    tick();
    ioctl_rd = 1'b0;
    chk("idx0_ram_rd", 32'(ram_rd), 32'd0);
    tick();
    chk("idx0_pause", 32'(cpu_pause), 32'd0);
    ioctl_upload = 1'b0;
    tick();

    // request timeout: 15 clocks with REQ_TMO=4
    cpu_write(16'hC123);
    save_trig = 1'b1;
    tick();
    save_trig = 1'b0;
    chk("trig_req", 32'(ioctl_upload_req), 32'd1);
    repeat (14) tick();
    chk("tmo_req_hold", 32'(ioctl_upload_req), 32'd1);
    tick();
    chk("tmo_req_drop", 32'(ioctl_upload_req), 32'd0);
    chk("tmo_dirty", 32'(dirty), 32'd1);
    save_trig = 1'b1;
    tick();
    save_trig = 1'b0;
    chk("tmo_idle_retrig", 32'(ioctl_upload_req), 32'd1);
    repeat (15) tick();
    chk("tmo2_req_drop", 32'(ioctl_upload_req), 32'd0);

    // reset in the middle of an upload
    ioctl_upload = 1'b1; ioctl_index = 8'd4;
    tick();
    chk("mid_pause", 32'(cpu_pause), 32'd1);
    reset_n = 1'b0;
    tick();
    ioctl_upload = 1'b0;
    chk("mid_rst_pause", 32'(cpu_pause), 32'd0);
    chk("mid_rst_dirty", 32'(dirty), 32'd0);
    reset_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
